sb_reg_access_ctrl: RTL

- Sequencer and arbiter in front of the sideband register file.
- Two requesters share it: remote AT command decoder (req0) and local link-config engine (req1).
- Breaks multi-byte writes into the per-byte s_write cycles the register file needs. Issues single-cycle s_read and captures the registered sb_read result.
- Screens illegal accesses and returns one response pulse per accepted request.

---
 rtl/sb_reg_pkg.sv | 44 ++++
 rtl/sb_reg_access_ctrl_if.sv | 53 +++++
 rtl/sb_rr_arbiter.sv | 33 +++
 rtl/sb_reg_access_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sb_reg_pkg.sv
// rtl/sb_reg_pkg.sv - shared types, address map and access screening helpers
//
// Purpose: FSM state encoding, top of the implemented byte space, the table
// of register base addresses and the read-only byte map used to screen
// sideband register accesses.
// Ports: none (package).

package sb_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

  // Highest implemented byte address of the register file.
  localparam int MEM_TOP = 156;

  localparam int NUM_REG = 11;
  localparam logic [7:0] REG_BASE [NUM_REG] = '{
    8'd0, 8'd4, 8'd8, 8'd66, 8'd70, 8'd74, 8'd78, 8'd81, 8'd85, 8'd89, 8'd93
  };

  // Reads are only legal at the first byte of a register.
  function automatic logic is_reg_base(input logic [7:0] a);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (a == REG_BASE[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Read-only bytes: 0-7, 78-82, 89-92. Address is 9 bits so that a burst
  // running past 255 never aliases back onto low addresses.
  function automatic logic is_ro_byte(input logic [8:0] a);
    return (a <= 9'd7) ||
           (a >= 9'd78 && a <= 9'd82) ||
           (a >= 9'd89 && a <= 9'd92);
  endfunction

endpackage

// File: rtl/sb_reg_access_ctrl_if.sv
// rtl/sb_reg_access_ctrl_if.sv - requester, register-file and response bus bundle
//
// Purpose: groups the two requester handshakes, the register-file strobes and
// the response channel of sb_reg_access_ctrl.
// Modports: slave  - the access controller (drives ready, s_*, rsp_*)
//           master - requesters plus register file (drive req*, sb_read)

interface sb_reg_access_ctrl_if;

  logic        req0_valid;
  logic        req0_write;
  logic [7:0]  req0_addr;
  logic [2:0]  req0_len;
  logic [31:0] req0_wdata;
  logic        req0_ready;

  logic        req1_valid;
  logic        req1_write;
  logic [7:0]  req1_addr;
  logic [2:0]  req1_len;
  logic [31:0] req1_wdata;
  logic        req1_ready;

  logic        s_read;
  logic        s_write;
  logic [7:0]  s_address;
  logic [7:0]  s_data;
  logic [23:0] sb_read;

  logic        rsp_valid;
  logic        rsp_id;
  logic [23:0] rsp_data;
  logic        rsp_err;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_len, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_len, req1_wdata,
    input  sb_read,
    output req0_ready, req1_ready,
    output s_read, s_write, s_address, s_data,
    output rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_len, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_len, req1_wdata,
    output sb_read,
    input  req0_ready, req1_ready,
    input  s_read, s_write, s_address, s_data,
    input  rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/sb_rr_arbiter.sv
// rtl/sb_rr_arbiter.sv - 2-way round-robin grant with last-grant pointer
//
// Purpose: picks one of two requesters; when both request, the one not
// granted last wins. The pointer only moves when the grant is taken.
// Ports: clk, rst (sync, active-high), req[1:0] requests, take commits the
//        current grant, gnt_valid any request, gnt_id granted index.

module sb_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_valid = |req;
    gnt_id    = (req == 2'b11) ? ~last_q : req[1];
    last_d    = last_q;
    if (take && gnt_valid) last_d = gnt_id;
  end

  // Reset to "req1 granted last" so req0 wins the first contest.
  always_ff @(posedge clk) begin
    if (rst) last_q <= 1'b1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/sb_reg_access_ctrl.sv
// rtl/sb_reg_access_ctrl.sv - arbitrating sequencer in front of the sideband register file
//
// Purpose: accepts one request at a time from two requesters, screens it,
// splits writes into per-byte s_write cycles, issues single-cycle reads and
// returns exactly one response pulse per accepted request.
// Ports: fsm_clk clock, rst sync active-high reset, bus (slave modport):
//        req0_*/req1_* request handshakes, s_* register-file strobes,
//        sb_read read data, rsp_* response channel. All outputs registered.

module sb_reg_access_ctrl #(
  parameter int MAX_LEN = 4
) (
  input  logic                  fsm_clk,
  input  logic                  rst,
  sb_reg_access_ctrl_if.slave   bus
);
  import sb_reg_pkg::*;

  state_e      state_q, state_d;
  logic        wr_q, wr_d, id_q, id_d, err_q, err_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  len_q, len_d, cnt_q, cnt_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready0_q, ready0_d, ready1_q, ready1_d;
  logic        s_read_q, s_read_d, s_write_q, s_write_d;
  logic [7:0]  s_address_q, s_address_d, s_data_q, s_data_d;
  logic        rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic [23:0] rsp_data_q, rsp_data_d;

  logic        take, arb_valid, arb_id;
  logic        sel_write, wr_err, sel_err;
  logic [7:0]  sel_addr;
  logic [2:0]  sel_len;
  logic [31:0] sel_wdata;
  logic [8:0]  byte_addr;

  sb_rr_arbiter u_arb (
    .clk       (fsm_clk),
    .rst       (rst),
    .req       ({bus.req1_valid, bus.req0_valid}),
    .take      (take),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  assign sel_write = arb_id ? bus.req1_write : bus.req0_write;
  assign sel_addr  = arb_id ? bus.req1_addr  : bus.req0_addr;
  assign sel_len   = arb_id ? bus.req1_len   : bus.req0_len;
  assign sel_wdata = arb_id ? bus.req1_wdata : bus.req0_wdata;

  // A burst is rejected as a whole if any of its bytes is out of range or
  // read-only, so nothing is ever partially written.
  always_comb begin
    wr_err    = (sel_len == 3'd0) || (int'(sel_len) > MAX_LEN);
    byte_addr = {1'b0, sel_addr};
    for (int k = 0; k < MAX_LEN; k++) begin
      byte_addr = {1'b0, sel_addr} + 9'(k);
      if (k < int'(sel_len) && (byte_addr > 9'(MEM_TOP) || is_ro_byte(byte_addr)))
        wr_err = 1'b1;
    end
  end

  assign sel_err = sel_write ? wr_err : !is_reg_base(sel_addr);

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    id_d        = id_q;
    err_d       = err_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    take        = 1'b0;
    ready0_d    = 1'b0;
    ready1_d    = 1'b0;
    s_read_d    = 1'b0;
    s_write_d   = 1'b0;
    s_address_d = 8'd0;
    s_data_d    = 8'd0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = 24'd0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          take     = 1'b1;
          ready0_d = !arb_id;
          ready1_d = arb_id;
          wr_d     = sel_write;
          id_d     = arb_id;
          addr_d   = sel_addr;
          len_d    = sel_len;
          wdata_d  = sel_wdata;
          err_d    = sel_err;
          cnt_d    = 3'd0;
          if (sel_err)        state_d = ST_RESP;
          else if (sel_write) state_d = ST_WRITE;
          else                state_d = ST_RD_ISSUE;
        end
      end
      ST_WRITE: begin
        s_write_d   = 1'b1;
        s_address_d = addr_q + {5'd0, cnt_q};
        s_data_d    = 8'(wdata_q >> {cnt_q, 3'b000});
        cnt_d       = cnt_q + 3'd1;
        if (cnt_q == len_q - 3'd1) state_d = ST_RESP;
      end
      ST_RD_ISSUE: begin
        s_read_d    = 1'b1;
        s_address_d = addr_q;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // For a read, the register file result is on sb_read during this
        // cycle (one cycle after the strobe), so it is sampled straight into
        // the response register.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_err_d   = err_q;
        rsp_data_d  = (wr_q || err_q) ? 24'd0 : bus.sb_read;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge fsm_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= 8'd0;
      len_q       <= 3'd0;
      cnt_q       <= 3'd0;
      wdata_q     <= 32'd0;
      ready0_q    <= 1'b0;
      ready1_q    <= 1'b0;
      s_read_q    <= 1'b0;
      s_write_q   <= 1'b0;
      s_address_q <= 8'd0;
      s_data_q    <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 24'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      id_q        <= id_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      ready0_q    <= ready0_d;
      ready1_q    <= ready1_d;
      s_read_q    <= s_read_d;
      s_write_q   <= s_write_d;
      s_address_q <= s_address_d;
      s_data_q    <= s_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.req0_ready = ready0_q;
  assign bus.req1_ready = ready1_q;
  assign bus.s_read     = s_read_q;
  assign bus.s_write    = s_write_q;
  assign bus.s_address  = s_address_q;
  assign bus.s_data     = s_data_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_data   = rsp_data_q;

endmodule
